msrv32_imem_responder: RTL
==========================

Name: msrv32_imem_responder

Overview:
- Instruction-side AHB-lite-style responder sitting at the far end of the fetch interface; answers the address the PC mux drives on iaddr, and generates the ready signal the PC mux consumes.
- Holds a word-addressed instruction store, inserts a programmable number of wait states, and returns an error response for misaligned or out-of-range fetches.
- Provides a synchronous load port so the store can be filled before or during execution.

Parameters:
- DEPTH, 1024, number of 32-bit instruction words; power of two, 2..65536.
- WAIT_STATES, 1, wait cycles per fetch (ready low) before the data phase completes; range 0..15.
- NOP_INSTR, 32'h00000013, value driven on instr_out at reset and on error responses.

Ports:
- clk_in  input  1  single clock; all state updates on the rising edge.
- rst_in  input  1  reset, asynchronous assert, active-low (0 = reset).
- req_in  input  1  fetch request; address phase is valid when req_in=1 and ready_out=1.
- iaddr_in  input  32  byte address of the fetch, sampled in the address phase.
- ready_out  output  1  AHB-style HREADY to the core (feeds the PC mux ahb_ready input).
- instr_valid_out  output  1  high for exactly one cycle per completed fetch (data phase end).
- resp_out  output  1  error response; high during both cycles of an error response.
- instr_out  output  32  fetched instruction, registered, held until the next completion.
- load_en_in  input  1  write strobe for the instruction store.
- load_addr_in  input  32  byte address of the load; bits [1:0] ignored, word index = load_addr_in[log2(DEPTH)+1:2].
- load_data_in  input  32  word written.

Behaviour:
- Reset (rst_in=0, asynchronous): state IDLE, ready_out=1, instr_valid_out=0, resp_out=0, instr_out=NOP_INSTR, wait counter=0. The store is not cleared. Any in-flight fetch is dropped with no completion. Reset release is synchronous to clk_in.
- States: IDLE, WAIT, DATA, ERR1, ERR2.
- IDLE: ready_out=1, instr_valid_out=0, resp_out=0.
- WAIT: ready_out=0, counter decrements each cycle.
- DATA: ready_out=1, instr_valid_out=1, resp_out=0.
- ERR1: ready_out=0, resp_out=1.
- ERR2: ready_out=1, resp_out=1, instr_valid_out=0.
- Address acceptance: only in IDLE, DATA or ERR2 (ready_out=1) with req_in=1. On acceptance, latch the word index and an error flag. The error flag is set when iaddr_in[1:0]!=0 or iaddr_in[31:2]>=DEPTH.
- Next state after acceptance:
  - error flag set -> ERR1;
  - else WAIT_STATES=0 -> DATA;
  - else -> WAIT, with counter loaded to WAIT_STATES-1.
- With no acceptance from IDLE/DATA/ERR2 -> IDLE.
- WAIT: if counter=0 -> DATA; else decrement and stay. Total latency from the acceptance edge to the DATA cycle is WAIT_STATES+1 cycles.
- Data capture: instr_out loads store[latched index] on the edge entering DATA. instr_valid_out is high in the DATA cycle only.
- Error response: ERR1 -> ERR2 unconditionally. instr_out loads NOP_INSTR on the edge entering ERR1.
- Pipelining: a request accepted in DATA or ERR2 starts the next fetch with no bubble. With WAIT_STATES=0, back-to-back requests complete one per cycle.
- Load port: load_en_in=1 writes load_data_in to store[word index] on the edge; it is accepted in any state and has no handshake.
- Load/read collision: a write on the same edge as the data capture to the same word returns the old contents (read-before-write). A write in an earlier WAIT cycle is visible.
- iaddr_in and req_in are ignored while ready_out=0.
- Counter width is 4 bits; no wrap past 0.

Test Plan:
- Reset/idle: hold rst_in=0 mid-WAIT, then release -> ready_out=1, instr_valid_out=0, resp_out=0, instr_out=32'h00000013; the aborted fetch never completes.
- Single fetch, WAIT_STATES=1: load word 4 = 32'h00500093; request iaddr 32'h10 -> ready_out=0 one cycle, next cycle ready_out=1, instr_valid_out=1, instr_out=32'h00500093.
- Back-to-back, WAIT_STATES=0: load words 0..3 = 32'hA0..A3; req_in high with iaddr 0,4,8,C on consecutive cycles -> instr_valid_out high four consecutive cycles returning A0..A3 in order, ready_out never low.
- Misaligned fetch: iaddr 32'h00000006 -> ERR1 (ready_out=0, resp_out=1), then ERR2 (ready_out=1, resp_out=1), instr_out=32'h00000013, instr_valid_out stays 0.
- Out-of-range fetch: DEPTH=1024, iaddr 32'h00001000 -> same two-cycle error. A request for iaddr 0 accepted in ERR2 -> completes normally after WAIT_STATES+1 cycles.
- Load collision, WAIT_STATES=2: word 8 = 32'h11111111; fetch 32'h20; write 32'h22222222 in the first WAIT cycle -> returns 32'h22222222. Repeat with the write on the capture edge -> returns the old value.

Source files
------------

// File: rtl/msrv32_imem_responder_if.sv
// Fetch-side bus between the core (master) and the instruction responder (slave),
// plus the store load port.
//
// Handshake: an address phase happens on a rising edge where req_in=1 and
// ready_out=1. req_in and iaddr_in are don't-care while ready_out=0. A fetch
// completes in the cycle where ready_out=1 and either instr_valid_out=1
// (good data) or resp_out=1 (error). The load port has no handshake; every
// edge with load_en_in=1 writes.
interface msrv32_imem_responder_if;
  logic        req_in;
  logic [31:0] iaddr_in;
  logic        ready_out;
  logic        instr_valid_out;
  logic        resp_out;
  logic [31:0] instr_out;
  logic        load_en_in;
  logic [31:0] load_addr_in;
  logic [31:0] load_data_in;

  modport slave (
    input  req_in, iaddr_in, load_en_in, load_addr_in, load_data_in,
    output ready_out, instr_valid_out, resp_out, instr_out
  );

  modport master (
    output req_in, iaddr_in, load_en_in, load_addr_in, load_data_in,
    input  ready_out, instr_valid_out, resp_out, instr_out
  );
endinterface

// File: rtl/msrv32_imem_responder.sv
// Instruction-side responder: word-addressed store with a load port,
// programmable wait states and a two-cycle error response for misaligned
// or out-of-range fetches.
//
// dbg_state_out encoding: 0=IDLE 1=WAIT 2=DATA 3=ERR1 4=ERR2.
module msrv32_imem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  msrv32_imem_responder_if.slave   bus,
  output logic [2:0]               dbg_state_out
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   mem_q [DEPTH];

  logic          addr_phase;
  logic          accept;
  logic          fetch_err;
  logic [AW-1:0] fetch_idx;
  logic [AW-1:0] load_idx;
  logic          unused_load_bits;

  // An address phase is only open while ready_out is high.
  assign addr_phase = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
  assign accept     = addr_phase && bus.req_in;
  assign fetch_err  = (bus.iaddr_in[1:0] != 2'b00) ||
                      ({2'b00, bus.iaddr_in[31:2]} >= 32'(DEPTH));
  assign fetch_idx  = bus.iaddr_in[AW+1:2];
  assign load_idx   = bus.load_addr_in[AW+1:2];

  // Byte-offset and above-depth load address bits carry no meaning.
  assign unused_load_bits = ^{bus.load_addr_in[31:AW+2], bus.load_addr_in[1:0]};

  // Instruction store write port; contents survive reset.
  always_ff @(posedge clk_in) begin
    if (bus.load_en_in) begin
      mem_q[load_idx] <= bus.load_data_in;
    end
  end

  // State, counter, latched index and output data registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      instr_q <= instr_d;
    end
  end

  // Next-state logic; data is captured on the edge entering DATA, so a store
  // write on that same edge is not yet visible (read-before-write).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    instr_d = instr_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR1: begin
        state_d = S_ERR2;
      end
      default: begin
        // IDLE, DATA and ERR2 all accept a new address with no bubble.
        if (accept) begin
          idx_d = fetch_idx;
          if (fetch_err) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = S_DATA;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
    if (state_d == S_DATA) begin
      instr_d = mem_q[idx_d];
    end else if (state_d == S_ERR1) begin
      instr_d = NOP_INSTR;
    end
  end

  // Bus outputs decoded from the current state.
  always_comb begin
    bus.ready_out       = 1'b0;
    bus.instr_valid_out = 1'b0;
    bus.resp_out        = 1'b0;
    case (state_q)
      S_IDLE: bus.ready_out = 1'b1;
      S_DATA: begin
        bus.ready_out       = 1'b1;
        bus.instr_valid_out = 1'b1;
      end
      S_ERR1: bus.resp_out = 1'b1;
      S_ERR2: begin
        bus.ready_out = 1'b1;
        bus.resp_out  = 1'b1;
      end
      default: bus.ready_out = 1'b0;
    endcase
  end

  assign bus.instr_out     = instr_q;
  assign dbg_state_out     = state_q;

endmodule
